// File: rtl/wokwi_394618582085551105.sv
// wokwi_394618582085551105 -- 8-bit register-transform engine (TinyTapeout microtile).
//
// Each rising clk edge, with en set, the state register r is loaded,
// accumulated, stepped as an 8-bit Fibonacci LFSR, or rotated left. The
// transform is chosen by the op field. With en clear, r holds.
//
// Ports:
//   clk     in   1  sole clock, rising edge
//   rst_n   in   1  synchronous active-low reset (r <= 0x00)
//   ui_in   in   8  [7:6] op, [5] en, [4:0] d
//   uo_out  out  8  r, or Gray(r) when WOKWI_GRAY_OUT_EN is defined
//
// Build option:
//   WOKWI_GRAY_OUT_EN  drive uo_out = r ^ (r >> 1) instead of r.
//                      Internal state and update rules are unchanged.

module wokwi_394618582085551105 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out
);

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_LFSR = 2'b10,
    OP_ROT  = 2'b11
  } op_e;

  op_e        op;
  logic       en;
  logic [4:0] d;
  logic [7:0] r;
  logic [7:0] r_next;
  logic [15:0] rot_dbl;
  logic       lfsr_fb;

  assign op = op_e'(ui_in[7:6]);
  assign en = ui_in[5];
  assign d  = ui_in[4:0];

  always_comb begin
    r_next  = r;
    // Shifting the doubled word gives the left rotation in its upper byte.
    rot_dbl = {r, r} << d[2:0];
    // Taps for x^8+x^6+x^5+x^4+1.
    lfsr_fb = r[7] ^ r[5] ^ r[4] ^ r[3];
    if (en) begin
      unique case (op)
        OP_LOAD: r_next = {3'b000, d};
        OP_ADD:  r_next = r + {3'b000, d};
        // The all-zero state would lock up, so escape it to 0x01.
        OP_LFSR: r_next = (r == 8'h00) ? 8'h01 : {r[6:0], lfsr_fb};
        OP_ROT:  r_next = rot_dbl[15:8];
        default: r_next = r;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r <= '0;
    else        r <= r_next;
  end

`ifdef WOKWI_GRAY_OUT_EN
  assign uo_out = r ^ (r >> 1);
`else
  assign uo_out = r;
`endif

endmodule

// File: tb/tb_wokwi_394618582085551105.sv
// Self-checking bench for wokwi_394618582085551105.
// Inputs change on falling edges. Outputs are sampled #1 after the rising edge.
// A behavioural model pushes each expected output onto a scoreboard queue as
// the stimulus is driven. The entry is popped and compared once the edge has
// passed.

module tb_wokwi_394618582085551105;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uo_out;

  int checks = 0;
  int failures = 0;

  logic [7:0] model_r = 8'h00;
  logic [7:0] sb_q[$];

  wokwi_394618582085551105 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ui_in  (ui_in),
    .uo_out (uo_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] out_map(input logic [7:0] v);
`ifdef WOKWI_GRAY_OUT_EN
    return v ^ {1'b0, v[7:1]};
`else
    return v;
`endif
  endfunction

  function automatic logic [7:0] model_next(input logic [7:0] cur, input logic [7:0] ui);
    logic [7:0] v;
    v = cur;
    if (ui[5]) begin
      case (ui[7:6])
        2'd0: v = ui & 8'h1F;
        2'd1: v = 8'((int'(cur) + int'(ui & 8'h1F)) % 256);
        2'd2: begin
          if (cur == 8'h00) v = 8'h01;
          else v = {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
        end
        default: begin
          for (int unsigned k = 0; k < 32'(ui[2:0]); k++) v = {v[6:0], v[7]};
        end
      endcase
    end
    return v;
  endfunction

  function automatic logic [7:0] mk_ui(input logic [1:0] op, input logic en, input logic [4:0] d);
    return {op, en, d};
  endfunction

  task automatic step(input logic rst, input logic [7:0] ui, input string tag);
    logic [7:0] exp;
    @(negedge clk);
    rst_n = rst;
    ui_in = ui;
    model_r = rst ? model_next(model_r, ui) : 8'h00;
    sb_q.push_back(out_map(model_r));
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 8'h01, 8'h00);
    end else begin
      exp = sb_q.pop_front();
      check_eq(tag, uo_out, exp);
    end
  endtask

  initial begin
    int zero_cnt;
    logic [7:0] held;

    // Reset with all control bits set, then idle with en=0.
    step(1'b0, 8'hFF, "reset0");
    step(1'b0, 8'hFF, "reset1");
    check_eq("reset_val", uo_out, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b1, mk_ui(2'd1, 1'b0, 5'h1F), "idle_hold");
    check_eq("idle_val", uo_out, 8'h00);

    // LOAD and ADD with wrap-around.
    step(1'b1, mk_ui(2'd0, 1'b1, 5'h1F), "load");
    check_eq("load_val", uo_out, out_map(8'h1F));
    for (int i = 0; i < 8; i++) step(1'b1, mk_ui(2'd1, 1'b1, 5'h1F), "add");
    check_eq("add_wrap_final", uo_out, out_map(8'h17));

    // LFSR starting at zero takes the escape to 0x01.
    step(1'b0, 8'h00, "reset_lfsr");
    step(1'b1, mk_ui(2'd2, 1'b1, 5'h00), "lfsr");
    check_eq("lfsr_escape", uo_out, out_map(8'h01));
    for (int i = 0; i < 4; i++) step(1'b1, mk_ui(2'd2, 1'b1, 5'h00), "lfsr");
    check_eq("lfsr_0x11", uo_out, out_map(8'h11));
    zero_cnt = 0;
    for (int i = 0; i < 255; i++) begin
      step(1'b1, mk_ui(2'd2, 1'b1, 5'h00), "lfsr_run");
      if (uo_out == 8'h00) zero_cnt++;
    end
    check_eq("lfsr_period", uo_out, out_map(8'h11));
    check_eq("lfsr_no_zero", 8'(zero_cnt), 8'h00);

    // ROT: shift 3, shift 5 through d=0x1D, and shift 0 through d=0x08.
    step(1'b1, mk_ui(2'd0, 1'b1, 5'h11), "rot_load");
    step(1'b1, mk_ui(2'd3, 1'b1, 5'h03), "rot3");
    check_eq("rot3_val", uo_out, out_map(8'h88));
    step(1'b1, mk_ui(2'd3, 1'b1, 5'h1D), "rot5");
    check_eq("rot5_val", uo_out, out_map(8'h11));
    step(1'b1, mk_ui(2'd3, 1'b1, 5'h08), "rot0");
    check_eq("rot0_val", uo_out, out_map(8'h11));

    // Hold during LFSR stepping, then a mid-sequence reset.
    for (int i = 0; i < 3; i++) step(1'b1, mk_ui(2'd2, 1'b1, 5'h00), "lfsr_pre_hold");
    held = uo_out;
    for (int i = 0; i < 4; i++) step(1'b1, mk_ui(2'd2, 1'b0, 5'h00), "hold");
    check_eq("hold_frozen", uo_out, held);

    // Reset is synchronous, so the output keeps its value until the edge.
    @(negedge clk);
    rst_n = 1'b0;
    ui_in = mk_ui(2'd1, 1'b1, 5'h05);
    #1;
    check_eq("rst_sync_wait", uo_out, held);
    model_r = 8'h00;
    sb_q.push_back(out_map(model_r));
    @(posedge clk);
    #1;
    check_eq("mid_reset", uo_out, sb_q.pop_front());
    step(1'b1, mk_ui(2'd1, 1'b1, 5'h05), "post_reset_add");
    check_eq("post_reset_val", uo_out, out_map(8'h05));

    check_eq("sb_drained", 8'(sb_q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
